// File: rtl/serial_bus_slave_pkg.sv
// Shared definitions for the serial bus slave: ID width, FSM state encoding
// and the two line levels used for framing.
package serial_bus_slave_pkg;

    localparam int   ID_WIDTH  = 2;
    localparam logic IDLE_BIT  = 1'b1;
    localparam logic START_BIT = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ID_RX,
        ST_ADDR_WAIT,
        ST_ADDR_RX,
        ST_DATA_WAIT,
        ST_DATA_RX,
        ST_READ_WAIT,
        ST_TX
    } state_t;

endpackage

// File: rtl/serial_bus_slave_shift_rx.sv
// MSB-first serial shift-in of one field with a bit counter; o_done marks the
// cycle in which the last bit is on the line, and o_word already includes it.
module serial_shift_rx
    import serial_bus_slave_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_en,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_word,
    output logic             o_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-2:0] r_shift;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] w_word;

    assign w_word = {r_shift, i_bit};
    assign o_word = w_word;
    assign o_done = i_en && (r_count == CW'(WIDTH - 1));

    // Holding i_en low keeps the field cleared, so every field starts at bit 0.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (!i_en) begin
            r_shift <= '0;
            r_count <= '0;
        end else begin
            r_shift <= w_word[WIDTH-2:0];
            r_count <= o_done ? '0 : r_count + CW'(1);
        end
    end

endmodule

// File: rtl/serial_bus_slave.sv
// Serial bus slave endpoint: decodes ID and address, receives write data or
// serves a read by shifting the local word back onto the shared line.
module serial_bus_slave
    import serial_bus_slave_pkg::*;
#(
    parameter int                  ADDRESS_WIDTH = 15,
    parameter int                  DATA_WIDTH    = 8,
    parameter logic [ID_WIDTH-1:0] SELF_ID       = 2'b11
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     rd_wrt,
    input  logic                     bus_util,
    input  logic                     module_dv,
    inout  wire                      data_bus_serial,
    inout  wire                      slave_busy,
    input  logic [DATA_WIDTH-1:0]    data_in_parellel,
    output logic                     write_en_internal,
    output logic [DATA_WIDTH-1:0]    data_out_parellel,
    output logic [ADDRESS_WIDTH-1:0] addr_buff
);

    localparam int FRAME_W = DATA_WIDTH + 2;
    localparam int TXCW    = $clog2(FRAME_W);

    state_t                   r_state;
    state_t                   w_nextState;
    logic                     w_rxBit;
    logic                     w_start;
    logic                     w_restart;
    logic [ID_WIDTH-1:0]      w_idWord;
    logic                     w_idDone;
    logic [ADDRESS_WIDTH-1:0] w_addrWord;
    logic                     w_addrDone;
    logic [DATA_WIDTH-1:0]    w_dataWord;
    logic                     w_dataDone;
    logic [FRAME_W-1:0]       r_txFrame;
    logic [TXCW-1:0]          r_txCount;
    logic                     w_txLast;

    // A floating or unknown line reads as idle so it can never fake a start bit.
    assign w_rxBit   = (data_bus_serial === START_BIT) ? START_BIT : IDLE_BIT;
    assign w_start   = (w_rxBit == START_BIT);
    assign w_restart = bus_util && w_start;
    assign w_txLast  = (r_txCount == TXCW'(FRAME_W - 1));

    serial_shift_rx #(.WIDTH(ID_WIDTH)) u_idRx (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_en   (r_state == ST_ID_RX),
        .i_bit  (w_rxBit),
        .o_word (w_idWord),
        .o_done (w_idDone)
    );

    serial_shift_rx #(.WIDTH(ADDRESS_WIDTH)) u_addrRx (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_en   (r_state == ST_ADDR_RX),
        .i_bit  (w_rxBit),
        .o_word (w_addrWord),
        .o_done (w_addrDone)
    );

    serial_shift_rx #(.WIDTH(DATA_WIDTH)) u_dataRx (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_en   (r_state == ST_DATA_RX),
        .i_bit  (w_rxBit),
        .o_word (w_dataWord),
        .o_done (w_dataDone)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_nextState;
    end

    // ID bits may legitimately be 0 while bus_util is high, so ID_RX cannot restart.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:      if (w_restart) w_nextState = ST_ID_RX;
            ST_ID_RX:     if (w_idDone) w_nextState = (w_idWord == SELF_ID) ? ST_ADDR_WAIT : ST_IDLE;
            ST_ADDR_WAIT: if (w_restart) w_nextState = ST_ID_RX;
                          else if (w_start) w_nextState = ST_ADDR_RX;
            ST_ADDR_RX:   if (w_restart) w_nextState = ST_ID_RX;
                          else if (w_addrDone) w_nextState = rd_wrt ? ST_DATA_WAIT : ST_READ_WAIT;
            ST_DATA_WAIT: if (w_restart) w_nextState = ST_ID_RX;
                          else if (w_start) w_nextState = ST_DATA_RX;
            ST_DATA_RX:   if (w_restart) w_nextState = ST_ID_RX;
                          else if (w_dataDone) w_nextState = ST_IDLE;
            ST_READ_WAIT: if (w_restart) w_nextState = ST_ID_RX;
                          else if (module_dv) w_nextState = ST_TX;
            ST_TX:        if (w_txLast) w_nextState = ST_IDLE;
            default:      w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_buff         <= '0;
            data_out_parellel <= '0;
            write_en_internal <= 1'b0;
            r_txFrame         <= '0;
            r_txCount         <= '0;
        end else begin
            write_en_internal <= (r_state == ST_DATA_RX) && (w_nextState == ST_IDLE);
            if ((r_state == ST_DATA_RX) && (w_nextState == ST_IDLE))
                data_out_parellel <= w_dataWord;
            if ((r_state == ST_ADDR_RX) &&
                ((w_nextState == ST_DATA_WAIT) || (w_nextState == ST_READ_WAIT)))
                addr_buff <= w_addrWord;
            // The frame carries start, payload and stop so TX is a plain left shift.
            if ((r_state == ST_READ_WAIT) && (w_nextState == ST_TX)) begin
                r_txFrame <= {START_BIT, data_in_parellel, IDLE_BIT};
                r_txCount <= '0;
            end else if (r_state == ST_TX) begin
                r_txFrame <= {r_txFrame[FRAME_W-2:0], IDLE_BIT};
                r_txCount <= r_txCount + TXCW'(1);
            end
        end
    end

    assign data_bus_serial = (r_state == ST_TX) ? r_txFrame[FRAME_W-1] : 1'bz;
    assign slave_busy      = ((r_state == ST_READ_WAIT) || (r_state == ST_TX)) ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_serial_bus_slave.sv
// Directed plus randomized bench for serial_bus_slave; expected values come
// from a transaction-level model of selection, address, write data and read frames.
module tb_serial_bus_slave;

    localparam int AW = 15;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          rd_wrt;
    logic          bus_util;
    logic          module_dv;
    logic [DW-1:0] data_in_parellel;
    logic          write_en_internal;
    logic [DW-1:0] data_out_parellel;
    logic [AW-1:0] addr_buff;
    logic          mDrive;
    logic          mBit;
    wire           dataBus;
    wire           busyLine;

    int            compCount = 0;
    int            failCount = 0;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expData;

    // Bus idles high through the pull-up; busy reads 0 whenever nobody drives it.
    pullup (dataBus);
    pulldown (busyLine);
    assign dataBus = mDrive ? mBit : 1'bz;

    serial_bus_slave #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .SELF_ID       (2'b11)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .rd_wrt            (rd_wrt),
        .bus_util          (bus_util),
        .module_dv         (module_dv),
        .data_bus_serial   (dataBus),
        .slave_busy        (busyLine),
        .data_in_parellel  (data_in_parellel),
        .write_en_internal (write_en_internal),
        .data_out_parellel (data_out_parellel),
        .addr_buff         (addr_buff)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic b);
        mDrive = 1'b1;
        mBit   = b;
        tick();
    endtask

    task automatic sendField(input logic [31:0] value, input int width);
        applyStimulus(1'b0);
        for (int i = width - 1; i >= 0; i--) applyStimulus(value[i]);
    endtask

    task automatic sendHeader(input logic [1:0] id);
        bus_util = 1'b1;
        applyStimulus(1'b0);
        applyStimulus(id[1]);
        applyStimulus(id[0]);
        bus_util = 1'b0;
    endtask

    task automatic doWrite(input logic [1:0] id, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic selected;
        selected = (id == 2'b11);
        sendHeader(id);
        rd_wrt = 1'b1;
        sendField(32'(addr), AW);
        if (selected) expAddr = addr;
        checkOutput("wr_addr", 32'(addr_buff), 32'(expAddr));
        checkOutput("wr_busy", 32'(busyLine), 32'd0);
        applyStimulus(1'b0);
        for (int i = DW - 1; i >= 1; i--) applyStimulus(data[i]);
        checkOutput("wr_strobe_early", 32'(write_en_internal), 32'd0);
        applyStimulus(data[0]);
        if (selected) expData = data;
        checkOutput("wr_strobe", 32'(write_en_internal), 32'(selected));
        checkOutput("wr_data", 32'(data_out_parellel), 32'(expData));
        applyStimulus(1'b1);
        checkOutput("wr_strobe_end", 32'(write_en_internal), 32'd0);
        rd_wrt = 1'b0;
    endtask

    task automatic doRead(input logic [1:0] id, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic          selected;
        logic [DW+1:0] frame;
        int            gap;
        selected = (id == 2'b11);
        frame    = {1'b0, data, 1'b1};
        sendHeader(id);
        rd_wrt = 1'b0;
        sendField(32'(addr), AW);
        if (selected) expAddr = addr;
        checkOutput("rd_addr", 32'(addr_buff), 32'(expAddr));
        checkOutput("rd_busy", 32'(busyLine), 32'(selected));
        gap = $urandom_range(0, 3);
        for (int i = 0; i < gap; i++) applyStimulus(1'b1);
        checkOutput("rd_busy_wait", 32'(busyLine), 32'(selected));
        mDrive           = 1'b0;
        data_in_parellel = data;
        module_dv        = 1'b1;
        tick();
        module_dv        = 1'b0;
        if (selected) begin
            for (int k = 0; k < DW + 2; k++) begin
                if (k > 0) tick();
                checkOutput($sformatf("rd_tx_bit%0d", k), 32'(dataBus), 32'(frame[DW+1-k]));
                checkOutput("rd_tx_busy", 32'(busyLine), 32'd1);
            end
            tick();
        end
        checkOutput("rd_release_bus", 32'(dataBus), 32'd1);
        checkOutput("rd_release_busy", 32'(busyLine), 32'd0);
        applyStimulus(1'b1);
    endtask

    initial begin
        logic [1:0]    id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;

        rstn = 1'b0; mDrive = 1'b0; mBit = 1'b1; bus_util = 1'b0;
        rd_wrt = 1'b0; module_dv = 1'b0; data_in_parellel = '0;
        expAddr = '0; expData = '0;
        $display("[TB] serial_bus_slave bench starting");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_addr", 32'(addr_buff), 32'd0);
        checkOutput("rst_wen", 32'(write_en_internal), 32'd0);
        checkOutput("rst_dout", 32'(data_out_parellel), 32'd0);
        checkOutput("rst_bus", 32'(dataBus), 32'd1);
        checkOutput("rst_busy", 32'(busyLine), 32'd0);
        rstn = 1'b1;
        applyStimulus(1'b1);
        applyStimulus(1'b1);

        doRead(2'b11, 15'h1234, 8'd159);
        doRead(2'b01, 15'h4321, 8'h3C);
        doWrite(2'b01, 15'h0777, 8'h11);
        doWrite(2'b11, 15'h0005, 8'hA5);

        // Abort part-way through an address with a fresh start, then finish a write.
        sendHeader(2'b11);
        rd_wrt = 1'b1;
        applyStimulus(1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'($urandom_range(0, 1)));
        doWrite(2'b11, 15'h2AAA, 8'h5A);

        for (int t = 0; t < 8; t++) begin
            id   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            addr = AW'($urandom);
            data = DW'($urandom);
            if ($urandom_range(0, 1) == 1) doWrite(id, addr, data);
            else                           doRead(id, addr, data);
        end

        // Reset in the middle of a read frame must release both lines at once.
        addr = AW'($urandom);
        sendHeader(2'b11);
        rd_wrt = 1'b0;
        sendField(32'(addr), AW);
        mDrive = 1'b0;
        data_in_parellel = DW'($urandom);
        module_dv = 1'b1;
        tick();
        module_dv = 1'b0;
        repeat (3) tick();
        checkOutput("midtx_busy", 32'(busyLine), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        expAddr = '0;
        expData = '0;
        checkOutput("midtx_rst_bus", 32'(dataBus), 32'd1);
        checkOutput("midtx_rst_busy", 32'(busyLine), 32'd0);
        checkOutput("midtx_rst_addr", 32'(addr_buff), 32'(expAddr));
        checkOutput("midtx_rst_wen", 32'(write_en_internal), 32'd0);
        rstn = 1'b1;
        applyStimulus(1'b1);
        doWrite(2'b11, AW'($urandom), DW'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
